maxnet_winner_decoder: RTL and testbench
========================================

Name: maxnet_winner_decoder

Overview:
- Receiving end of the Maxnet winner-index path. Takes the 2-bit winner index plus a "no winner" flag produced at the end of Maxnet iteration and decodes them back into a one-hot neuron select.
- Returns the winner's original (pre-inhibition) input value, which it captured at load time.
- Sits between the Maxnet datapath/controller and the result consumer. Presents the result with a valid/ready handshake and holds it until the consumer accepts it.

Parameters:
- DATA_WIDTH, 8, width of each original Maxnet input value and of out_value.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  capture in_data1..in_data4 (start of a new Maxnet run).
- in_data1  input  DATA_WIDTH  original value of neuron 1.
- in_data2  input  DATA_WIDTH  original value of neuron 2.
- in_data3  input  DATA_WIDTH  original value of neuron 3.
- in_data4  input  DATA_WIDTH  original value of neuron 4.
- enc_valid  input  1  winner index is valid this cycle (Maxnet done).
- enc_index  input  2  winner index: 00=n1, 01=n2, 10=n3, 11=n4.
- enc_none  input  1  no neuron survived; enc_index is don't-care.
- out_ready  input  1  consumer accepts the result.
- out_valid  output  1  result registers hold a valid result.
- out_onehot  output  4  decoded select; bit0=n1 ... bit3=n4.
- out_index  output  2  registered copy of the accepted enc_index.
- out_value  output  DATA_WIDTH  original value of the winning neuron.
- out_none  output  1  result is "no winner".
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. out_valid=0, out_onehot=0000, out_index=00, out_value=0, out_none=0, busy=0. All four data registers cleared. Reset takes effect immediately, including mid-run or mid-HOLD; any pending result is discarded.
- All outputs are registered. There is no combinational path from any input to any output.
- State machine:
  - IDLE: load=1 -> capture in_data1..4, go to LOADED. enc_valid in IDLE is ignored because no operands are held.
  - LOADED: enc_valid=1 -> capture the result, go to HOLD. Otherwise, load=1 -> recapture in_data1..4 and stay in LOADED.
  - Simultaneous load and enc_valid in LOADED: enc_valid wins, the previously stored data is used, and load is ignored.
  - HOLD: out_valid=1. All out_* stay stable until out_ready=1. On out_ready=1 the state goes to IDLE at that edge and out_valid drops to 0; the other out_* retain their values.
  - load and enc_valid are ignored throughout HOLD, including the handshake cycle.
- Latency: enc_valid sampled at edge k gives out_valid=1 from edge k onward (one-cycle register latency). Minimum accept-to-next-load spacing is one cycle through IDLE.
- Decode on capture, enc_none=0:
  - out_onehot = 1 << enc_index.
  - out_index = enc_index.
  - out_value = stored data of the selected neuron.
  - out_none = 0.
- Decode on capture, enc_none=1: out_onehot=0000, out_index=00, out_value=0, out_none=1. This resolves the upstream 00 ambiguity between "neuron 1 wins" and "all neurons zero".
- X-safety: if enc_index carries X/Z while enc_valid=1 and enc_none=0, the result registers are unspecified. A simulation assertion flags this condition. The state machine still advances to HOLD.
- busy = (state != IDLE).

Test Plan:
- Reset and idle: hold rst_n=0, then release and wait 3 idle cycles -> all outputs 0 and busy=0. Pulse enc_valid=1, enc_index=10 while in IDLE -> out_valid stays 0.
- Basic decode: load with in_data = 12,40,7,33, then enc_valid with enc_index=01 -> next cycle out_valid=1, out_onehot=0010, out_index=01, out_value=40, out_none=0. Assert out_ready for one cycle -> out_valid=0 and busy=0.
- No winner: load 0,0,0,0, then enc_valid with enc_none=1 and enc_index=00 -> out_onehot=0000, out_value=0, out_none=1.
- Backpressure and ignored events: index 11 with data 5,6,7,200 -> out_value=200. Hold out_ready=0 for 5 cycles while pulsing load (data 1,1,1,1) and enc_valid (index 00) -> outputs unchanged. Then out_ready=1 -> IDLE.
- Priority and reload: load A=9,8,7,6, then load B=1,2,3,4, then a cycle with load C=50,50,50,50 and enc_valid with index 10 in the same cycle -> out_value=3 (B used, C ignored).
- Async reset mid-HOLD: drop rst_n while out_valid=1 and between clock edges -> out_valid=0 immediately. Then a full load/enc_valid run (index 00, in_data1=77) -> out_value=77, proving the state machine recovered.

Source files
------------

// File: rtl/maxnet_winner_decoder_if.sv
// Signal bundle between the Maxnet datapath/controller, the winner decoder and the result consumer.
// The master side drives operands, the winner index and out_ready; the slave side is the decoder.
interface maxnet_winner_decoder_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  load;
  logic [DATA_WIDTH-1:0] in_data1;
  logic [DATA_WIDTH-1:0] in_data2;
  logic [DATA_WIDTH-1:0] in_data3;
  logic [DATA_WIDTH-1:0] in_data4;
  logic                  enc_valid;
  logic [1:0]            enc_index;
  logic                  enc_none;
  logic                  out_ready;
  logic                  out_valid;
  logic [3:0]            out_onehot;
  logic [1:0]            out_index;
  logic [DATA_WIDTH-1:0] out_value;
  logic                  out_none;
  logic                  busy;

  modport master (
    output load, in_data1, in_data2, in_data3, in_data4,
    output enc_valid, enc_index, enc_none, out_ready,
    input  out_valid, out_onehot, out_index, out_value, out_none, busy
  );

  modport slave (
    input  load, in_data1, in_data2, in_data3, in_data4,
    input  enc_valid, enc_index, enc_none, out_ready,
    output out_valid, out_onehot, out_index, out_value, out_none, busy
  );
endinterface

// File: rtl/maxnet_winner_decoder.sv
// Decodes the Maxnet winner index into a one-hot select and returns the winner's
// original input value, held behind a valid/ready handshake until accepted.
module maxnet_winner_decoder #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  maxnet_winner_decoder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t                state;
  state_t                next_state;
  logic                  capture_data;
  logic                  capture_result;
  logic [DATA_WIDTH-1:0] data_q [4];
  logic [DATA_WIDTH-1:0] selected_value;
  logic [3:0]            onehot_q;
  logic [1:0]            index_q;
  logic [DATA_WIDTH-1:0] value_q;
  logic                  none_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A winner arriving in LOADED takes priority over a same-cycle reload.
  always_comb begin
    next_state     = state;
    capture_data   = 1'b0;
    capture_result = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.load) begin
          capture_data = 1'b1;
          next_state   = LOADED;
        end
      end
      LOADED: begin
        if (bus.enc_valid) begin
          capture_result = 1'b1;
          next_state     = HOLD;
        end else if (bus.load) begin
          capture_data = 1'b1;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      data_q[2] <= '0;
      data_q[3] <= '0;
    end else if (capture_data) begin
      data_q[0] <= bus.in_data1;
      data_q[1] <= bus.in_data2;
      data_q[2] <= bus.in_data3;
      data_q[3] <= bus.in_data4;
    end
  end

  assign selected_value = data_q[bus.enc_index];

  // "No winner" forces a distinct all-zero result so it cannot be confused with neuron 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      onehot_q <= 4'b0000;
      index_q  <= 2'b00;
      value_q  <= '0;
      none_q   <= 1'b0;
    end else if (capture_result) begin
      if (bus.enc_none) begin
        onehot_q <= 4'b0000;
        index_q  <= 2'b00;
        value_q  <= '0;
        none_q   <= 1'b1;
      end else begin
        onehot_q <= 4'b0001 << bus.enc_index;
        index_q  <= bus.enc_index;
        value_q  <= selected_value;
        none_q   <= 1'b0;
      end
    end
  end

  assign bus.out_valid  = (state == HOLD);
  assign bus.busy       = (state != IDLE);
  assign bus.out_onehot = onehot_q;
  assign bus.out_index  = index_q;
  assign bus.out_value  = value_q;
  assign bus.out_none   = none_q;

  // An unknown winner index at capture would leave the result registers undefined.
  assert property (@(posedge clk) disable iff (!rst_n)
    (state == LOADED && bus.enc_valid && !bus.enc_none) |-> !$isunknown(bus.enc_index));

endmodule

// File: tb/tb_maxnet_winner_decoder.sv
// Self-checking bench for maxnet_winner_decoder: directed vector table, async reset
// sequence, then random traffic compared against a transaction-level reference model.
module tb_maxnet_winner_decoder;

  localparam int DW = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  maxnet_winner_decoder_if #(.DATA_WIDTH(DW)) bus ();

  maxnet_winner_decoder #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed expectation: {valid, onehot[3:0], index[1:0], value[7:0], none, busy}
  typedef struct {
    logic          load;
    logic [DW-1:0] d [4];
    logic          ev;
    logic [1:0]    idx;
    logic          none;
    logic          rdy;
    logic [16:0]   exp;
  } vec_t;

  vec_t vq[$];

  // Reference model state: operands, whether a run is armed, and the pending result.
  logic          m_have_ops;
  logic          m_pending;
  logic [DW-1:0] m_ops [4];
  logic [3:0]    m_oh;
  logic [1:0]    m_ix;
  logic [DW-1:0] m_val;
  logic          m_none;

  function automatic logic [16:0] pack_exp(input logic v, input logic [3:0] oh,
                                           input logic [1:0] ix, input int val,
                                           input logic n, input logic b);
    return {v, oh, ix, 8'(val), n, b};
  endfunction

  function automatic vec_t mk_vec(input logic ld, input int a, input int b, input int c,
                                  input int d, input logic ev, input logic [1:0] ix,
                                  input logic nn, input logic rd, input logic [16:0] e);
    vec_t v;
    v.load = ld;
    v.d[0] = 8'(a);
    v.d[1] = 8'(b);
    v.d[2] = 8'(c);
    v.d[3] = 8'(d);
    v.ev   = ev;
    v.idx  = ix;
    v.none = nn;
    v.rdy  = rd;
    v.exp  = e;
    return v;
  endfunction

  function automatic logic [16:0] actual_out();
    return {bus.out_valid, bus.out_onehot, bus.out_index, bus.out_value, bus.out_none, bus.busy};
  endfunction

  task automatic drive(input logic ld, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] c, input logic [DW-1:0] d, input logic ev,
                       input logic [1:0] ix, input logic nn, input logic rd);
    bus.load      = ld;
    bus.in_data1  = a;
    bus.in_data2  = b;
    bus.in_data3  = c;
    bus.in_data4  = d;
    bus.enc_valid = ev;
    bus.enc_index = ix;
    bus.enc_none  = nn;
    bus.out_ready = rd;
  endtask

  // Drive inputs on the falling edge; results are sampled 1 time unit after the rising edge.
  task automatic apply_stimulus(input logic ld, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic [DW-1:0] c, input logic [DW-1:0] d, input logic ev,
                                input logic [1:0] ix, input logic nn, input logic rd);
    @(negedge clk);
    drive(ld, a, b, c, d, ev, ix, nn, rd);
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [16:0] exp);
    logic [16:0] act;
    act = actual_out();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got valid=%b onehot=%b index=%b value=%0d none=%b busy=%b, expected valid=%b onehot=%b index=%b value=%0d none=%b busy=%b",
               name, act[16], act[15:12], act[11:10], act[9:2], act[1], act[0],
               exp[16], exp[15:12], exp[11:10], exp[9:2], exp[1], exp[0]);
    end
  endtask

  function automatic void model_reset();
    m_have_ops = 1'b0;
    m_pending  = 1'b0;
    for (int i = 0; i < 4; i++) m_ops[i] = '0;
    m_oh   = 4'b0000;
    m_ix   = 2'b00;
    m_val  = '0;
    m_none = 1'b0;
  endfunction

  // One clock of the transaction model: accept, else resolve a winner, else (re)load.
  function automatic void model_step(input logic ld, input logic [DW-1:0] d [4], input logic ev,
                                     input logic [1:0] ix, input logic nn, input logic rd);
    if (m_pending) begin
      if (rd) m_pending = 1'b0;
    end else if (m_have_ops && ev) begin
      m_pending  = 1'b1;
      m_have_ops = 1'b0;
      m_none     = nn;
      m_ix       = nn ? 2'b00 : ix;
      m_val      = nn ? '0 : m_ops[ix];
      for (int i = 0; i < 4; i++) m_oh[i] = !nn && (i == int'(ix));
    end else if (ld) begin
      for (int i = 0; i < 4; i++) m_ops[i] = d[i];
      m_have_ops = 1'b1;
    end
  endfunction

  function automatic logic [16:0] model_exp();
    return {m_pending, m_oh, m_ix, m_val, m_none, m_have_ops | m_pending};
  endfunction

  initial begin
    logic [DW-1:0] rd_data [4];
    logic          r_ld;
    logic          r_ev;
    logic [1:0]    r_ix;
    logic          r_nn;
    logic          r_rd;

    checks   = 0;
    failures = 0;

    // Directed table: each row is one cycle of inputs and the outputs expected after that edge.
    vq.push_back(mk_vec(0,  0,  0,  0,   0, 1, 2'b10, 0, 0, pack_exp(0, 4'b0000, 2'b00,   0, 0, 0)));
    vq.push_back(mk_vec(1, 12, 40,  7,  33, 0, 2'b00, 0, 0, pack_exp(0, 4'b0000, 2'b00,   0, 0, 1)));
    vq.push_back(mk_vec(0,  0,  0,  0,   0, 1, 2'b01, 0, 0, pack_exp(1, 4'b0010, 2'b01,  40, 0, 1)));
    vq.push_back(mk_vec(0,  0,  0,  0,   0, 0, 2'b00, 0, 1, pack_exp(0, 4'b0010, 2'b01,  40, 0, 0)));
    vq.push_back(mk_vec(1,  0,  0,  0,   0, 0, 2'b00, 0, 0, pack_exp(0, 4'b0010, 2'b01,  40, 0, 1)));
    vq.push_back(mk_vec(0,  0,  0,  0,   0, 1, 2'b00, 1, 0, pack_exp(1, 4'b0000, 2'b00,   0, 1, 1)));
    vq.push_back(mk_vec(0,  0,  0,  0,   0, 0, 2'b00, 0, 1, pack_exp(0, 4'b0000, 2'b00,   0, 1, 0)));
    vq.push_back(mk_vec(1,  5,  6,  7, 200, 0, 2'b00, 0, 0, pack_exp(0, 4'b0000, 2'b00,   0, 1, 1)));
    vq.push_back(mk_vec(0,  0,  0,  0,   0, 1, 2'b11, 0, 0, pack_exp(1, 4'b1000, 2'b11, 200, 0, 1)));
    for (int i = 0; i < 5; i++)
      vq.push_back(mk_vec(i % 2 == 0, 1, 1, 1, 1, i % 2 == 1, 2'b00, 0, 0,
                          pack_exp(1, 4'b1000, 2'b11, 200, 0, 1)));
    vq.push_back(mk_vec(0,  0,  0,  0,   0, 0, 2'b00, 0, 1, pack_exp(0, 4'b1000, 2'b11, 200, 0, 0)));
    vq.push_back(mk_vec(1,  9,  8,  7,   6, 0, 2'b00, 0, 0, pack_exp(0, 4'b1000, 2'b11, 200, 0, 1)));
    vq.push_back(mk_vec(1,  1,  2,  3,   4, 0, 2'b00, 0, 0, pack_exp(0, 4'b1000, 2'b11, 200, 0, 1)));
    vq.push_back(mk_vec(1, 50, 50, 50,  50, 1, 2'b10, 0, 0, pack_exp(1, 4'b0100, 2'b10,   3, 0, 1)));
    vq.push_back(mk_vec(1, 99, 99, 99,  99, 1, 2'b00, 0, 1, pack_exp(0, 4'b0100, 2'b10,   3, 0, 0)));
    vq.push_back(mk_vec(0,  0,  0,  0,   0, 1, 2'b00, 0, 0, pack_exp(0, 4'b0100, 2'b10,   3, 0, 0)));

    drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_asserted", pack_exp(0, 4'b0000, 2'b00, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    check_output("idle_after_reset", pack_exp(0, 4'b0000, 2'b00, 0, 0, 0));

    for (int i = 0; i < vq.size(); i++) begin
      apply_stimulus(vq[i].load, vq[i].d[0], vq[i].d[1], vq[i].d[2], vq[i].d[3],
                     vq[i].ev, vq[i].idx, vq[i].none, vq[i].rdy);
      check_output($sformatf("vec%0d", i), vq[i].exp);
    end

    // Asynchronous reset between clock edges while a result is held.
    apply_stimulus(1, 11, 22, 33, 44, 0, 2'b00, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 1, 2'b01, 0, 0);
    check_output("hold_before_reset", pack_exp(1, 4'b0010, 2'b01, 22, 0, 1));
    #1;
    rst_n = 1'b0;
    #1;
    check_output("async_reset_mid_hold", pack_exp(0, 4'b0000, 2'b00, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(1, 77, 1, 2, 3, 0, 2'b00, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 1, 2'b00, 0, 0);
    check_output("recover_after_reset", pack_exp(1, 4'b0001, 2'b00, 77, 0, 1));
    apply_stimulus(0, 0, 0, 0, 0, 0, 2'b00, 0, 1);
    check_output("recover_accept", pack_exp(0, 4'b0001, 2'b00, 77, 0, 0));

    // Random traffic against the reference model, starting from a fresh reset.
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int n = 0; n < 400; n++) begin
      r_ld = ($urandom_range(0, 2) == 0);
      r_ev = ($urandom_range(0, 2) == 0);
      r_ix = 2'($urandom_range(0, 3));
      r_nn = ($urandom_range(0, 3) == 0);
      r_rd = ($urandom_range(0, 1) == 0);
      for (int i = 0; i < 4; i++) rd_data[i] = 8'($urandom_range(0, 255));
      apply_stimulus(r_ld, rd_data[0], rd_data[1], rd_data[2], rd_data[3], r_ev, r_ix, r_nn, r_rd);
      model_step(r_ld, rd_data, r_ev, r_ix, r_nn, r_rd);
      check_output($sformatf("random%0d", n), model_exp());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
